// File: rtl/sequenceur_lancer.sv
// Multi-dice roll sequencer: latches die type/count on lancer, draws bounded samples, sums them; lancer ignored while busy.
// Roll = 1 start + samples drawn + 1 FIN cycle; define ALEA_EXTERNE_EN to take samples from the alea port instead of the LFSR.
module sequenceur_lancer #(
   parameter logic [15:0] GRAINE = 16'hACE1,
   parameter int          NB_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lancer,
   input  logic [2:0]  id_de,
   input  logic [3:0]  nb_des,
`ifdef ALEA_EXTERNE_EN
   input  logic [6:0]  alea,
`endif
   output logic        occupe,
   output logic        resultat_valide,
   output logic [6:0]  dernier_resultat,
   output logic [10:0] total,
   output logic        fini
);

   localparam int          CW     = $clog2(NB_MAX + 1);
   localparam logic [15:0] SEED   = (GRAINE == 16'h0000) ? 16'h0001 : GRAINE;
   localparam logic [1:0]  REPOS  = 2'd0;
   localparam logic [1:0]  TIRAGE = 2'd1;
   localparam logic [1:0]  FIN    = 2'd2;

   logic [1:0]    etat_q, etat_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [2:0]    id_q, id_d;
   logic [CW-1:0] nb_q, nb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          occupe_q, occupe_d;
   logic          valide_q, valide_d;
   logic          fini_q, fini_d;
   logic [6:0]    dernier_q, dernier_d;
   logic [10:0]   total_q, total_d;
   logic [6:0]    echantillon;
   logic [6:0]    faces;
   logic [6:0]    valeur;
   logic          min_un;

`ifdef ALEA_EXTERNE_EN
   assign echantillon = alea;
`else
   assign echantillon = lfsr_q[6:0];
`endif

   // Die decode always uses the latched id so mid-roll input changes are harmless.
   always_comb begin
      faces  = 7'd100;
      min_un = 1'b1;
      case (id_q)
         3'd0:    faces = 7'd4;
         3'd1:    faces = 7'd6;
         3'd2:    faces = 7'd8;
         3'd3:    begin faces = 7'd10;  min_un = 1'b0; end
         3'd4:    faces = 7'd12;
         3'd5:    faces = 7'd20;
         3'd6:    faces = 7'd30;
         default: begin faces = 7'd100; min_un = 1'b0; end
      endcase
      valeur = echantillon + {6'd0, min_un};
   end

   always_comb begin
      etat_d    = etat_q;
      lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      id_d      = id_q;
      nb_d      = nb_q;
      cnt_d     = cnt_q;
      occupe_d  = occupe_q;
      valide_d  = 1'b0;
      fini_d    = 1'b0;
      dernier_d = dernier_q;
      total_d   = total_q;
      case (etat_q)
         REPOS: begin
            if (lancer) begin
               id_d     = id_de;
               nb_d     = nb_des[CW-1:0];
               cnt_d    = '0;
               total_d  = '0;
               occupe_d = 1'b1;
               etat_d   = (nb_des == 4'd0) ? FIN : TIRAGE;
            end
         end
         TIRAGE: begin
            // Rejection sampling: out-of-range samples cost a cycle and change nothing.
            if (echantillon < faces) begin
               dernier_d = valeur;
               total_d   = total_q + {4'd0, valeur};
               cnt_d     = cnt_q + CW'(1);
               valide_d  = 1'b1;
               if (cnt_d == nb_q) begin
                  etat_d = FIN;
               end
            end
         end
         FIN: begin
            fini_d   = 1'b1;
            occupe_d = 1'b0;
            etat_d   = REPOS;
         end
         default: etat_d = REPOS;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         etat_q    <= REPOS;
         lfsr_q    <= SEED;
         id_q      <= '0;
         nb_q      <= '0;
         cnt_q     <= '0;
         occupe_q  <= 1'b0;
         valide_q  <= 1'b0;
         fini_q    <= 1'b0;
         dernier_q <= '0;
         total_q   <= '0;
      end else begin
         etat_q    <= etat_d;
         lfsr_q    <= lfsr_d;
         id_q      <= id_d;
         nb_q      <= nb_d;
         cnt_q     <= cnt_d;
         occupe_q  <= occupe_d;
         valide_q  <= valide_d;
         fini_q    <= fini_d;
         dernier_q <= dernier_d;
         total_q   <= total_d;
      end
   end

   assign occupe           = occupe_q;
   assign resultat_valide  = valide_q;
   assign dernier_resultat = dernier_q;
   assign total            = total_q;
   assign fini             = fini_q;

endmodule

// File: tb/tb_sequenceur_lancer.sv
// Bench for sequenceur_lancer: directed rolls with hand-computed results when ALEA_EXTERNE_EN is defined,
// plus bound/sum/latency checks on every roll in either build.
`timescale 1ns/1ps
module tb_sequenceur_lancer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lancer = 1'b0;
   logic [2:0]  id_de = 3'd0;
   logic [3:0]  nb_des = 4'd0;
   logic [6:0]  tb_alea = 7'd0;
   logic        occupe;
   logic        resultat_valide;
   logic [6:0]  dernier_resultat;
   logic [10:0] total;
   logic        fini;

   always #5 clk = ~clk;

   sequenceur_lancer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .lancer           (lancer),
      .id_de            (id_de),
      .nb_des           (nb_des),
`ifdef ALEA_EXTERNE_EN
      .alea             (tb_alea),
`endif
      .occupe           (occupe),
      .resultat_valide  (resultat_valide),
      .dernier_resultat (dernier_resultat),
      .total            (total),
      .fini             (fini)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic verifier(input string tag, input logic [31:0] obs, input logic [31:0] att);
      n_cmp++;
      if (obs !== att) begin
         n_err++;
         $display("FAIL %s : observed %0d expected %0d", tag, obs, att);
      end
   endtask

   int          alea_q[$];
   int          res_q[$];
   int          res_edge[$];
   int          fini_edge;
   int          n_fini;
   int          occ_err;
   logic [10:0] tot_fin;

   function automatic logic [6:0] next_alea();
      if (alea_q.size() > 0) return 7'(alea_q.pop_front());
      return 7'($urandom_range(0, 127));
   endfunction

   function automatic int res_at(input int i);
      if (res_q.size() > i) return res_q[i];
      return -1;
   endfunction

   function automatic int edge_at(input int i);
      if (res_edge.size() > i) return res_edge[i];
      return -1;
   endfunction

   // Edge k = k-th rising edge after the one that samples lancer; outputs observed on the following falling edge.
   task automatic lancer_roll(input logic [2:0] id, input logic [3:0] nb, input int budget,
                              input int relance_at, input int reset_after);
      int n_rst_fini;
      res_q.delete();
      res_edge.delete();
      fini_edge = -1;
      n_fini    = 0;
      occ_err   = 0;
      tot_fin   = '0;
      @(negedge clk);
      if (occupe) occ_err++;
      lancer = 1'b1; id_de = id; nb_des = nb; tb_alea = 7'd0;
      @(negedge clk);
      lancer = 1'b0; id_de = ~id; nb_des = ~nb;
      if (!occupe) occ_err++;
      tb_alea = next_alea();
      for (int e = 1; e <= budget; e++) begin
         @(negedge clk);
         if (resultat_valide) begin
            res_q.push_back(int'(dernier_resultat));
            res_edge.push_back(e);
         end
         if (fini) begin
            n_fini++;
            if (fini_edge < 0) begin
               fini_edge = e;
               tot_fin   = total;
            end
            if (occupe) occ_err++;
         end else if (fini_edge < 0 && !occupe) begin
            occ_err++;
         end else if (fini_edge >= 0 && occupe) begin
            occ_err++;
         end
         if (e == relance_at) begin
            lancer = 1'b1; id_de = 3'd0; nb_des = 4'd1;
         end else begin
            lancer = 1'b0;
         end
         tb_alea = next_alea();
         if (reset_after > 0 && res_q.size() == reset_after) begin
            rst_n = 1'b0;
            #1;
            verifier("rst_mid_occupe", occupe, 0);
            verifier("rst_mid_total", total, 0);
            verifier("rst_mid_valide", resultat_valide, 0);
            verifier("rst_mid_fini", fini, 0);
            n_rst_fini = 0;
            repeat (3) begin
               @(negedge clk);
               if (fini) n_rst_fini++;
            end
            verifier("rst_mid_pas_de_fini", n_rst_fini, 0);
            rst_n = 1'b1;
            break;
         end
         if (fini_edge >= 0 && e >= fini_edge + 2) break;
      end
   endtask

   task automatic verif_roll(input string tag, input int nb, input int lo, input int hi);
      int somme, hors, lat;
      somme = 0;
      hors  = 0;
      foreach (res_q[i]) begin
         somme += res_q[i];
         if (res_q[i] < lo || res_q[i] > hi) hors++;
      end
      lat = (res_edge.size() > 0) ? res_edge[res_edge.size()-1] + 1 : 1;
      verifier({tag, "_nb_fini"}, n_fini, 1);
      verifier({tag, "_nb_res"}, res_q.size(), nb);
      verifier({tag, "_hors_bornes"}, hors, 0);
      verifier({tag, "_total"}, tot_fin, somme);
      verifier({tag, "_occupe"}, occ_err, 0);
      verifier({tag, "_lat_fini"}, fini_edge, lat);
      verifier({tag, "_total_tient"}, total, tot_fin);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      verifier("reset_occupe", occupe, 0);
      verifier("reset_valide", resultat_valide, 0);
      verifier("reset_dernier", dernier_resultat, 0);
      verifier("reset_total", total, 0);
      verifier("reset_fini", fini, 0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef ALEA_EXTERNE_EN
      alea_q = '{2, 9, 5, 0};
      lancer_roll(3'd1, 4'd3, 20, -1, -1);
      verif_roll("d6", 3, 1, 6);
      verifier("d6_r0", res_at(0), 3);
      verifier("d6_r1", res_at(1), 6);
      verifier("d6_r2", res_at(2), 1);
      verifier("d6_e0", edge_at(0), 1);
      verifier("d6_e1", edge_at(1), 3);
      verifier("d6_e2", edge_at(2), 4);
      verifier("d6_fini_edge", fini_edge, 5);
      verifier("d6_total", tot_fin, 10);

      alea_q = '{100, 99, 0};
      lancer_roll(3'd7, 4'd2, 20, -1, -1);
      verif_roll("d100", 2, 0, 99);
      verifier("d100_r0", res_at(0), 99);
      verifier("d100_r1", res_at(1), 0);
      verifier("d100_fini_edge", fini_edge, 4);
      verifier("d100_total", tot_fin, 99);

      alea_q = '{9};
      lancer_roll(3'd3, 4'd1, 20, -1, -1);
      verif_roll("d10", 1, 0, 9);
      verifier("d10_r0", res_at(0), 9);

      alea_q = '{3, 25, 19, 0, 7};
      lancer_roll(3'd5, 4'd4, 20, 2, -1);
      verif_roll("d20_occupe", 4, 1, 20);
      verifier("d20_r1", res_at(1), 20);
      verifier("d20_total", tot_fin, 33);
      alea_q.delete();
`endif

      lancer_roll(3'd2, 4'd0, 20, -1, -1);
      verif_roll("nb0", 0, 1, 8);
      verifier("nb0_fini_edge", fini_edge, 1);
      verifier("nb0_total", tot_fin, 0);

      lancer_roll(3'd5, 4'd4, 3000, 3, -1);
      verif_roll("relance_ignoree", 4, 1, 20);

      lancer_roll(3'd7, 4'd2, 3000, -1, -1);
      verif_roll("min0_d100", 2, 0, 99);
      lancer_roll(3'd3, 4'd1, 3000, -1, -1);
      verif_roll("min0_d10", 1, 0, 9);

      lancer_roll(3'd4, 4'd5, 3000, -1, 2);
      lancer_roll(3'd4, 4'd5, 3000, -1, -1);
      verif_roll("apres_rst", 5, 1, 12);

      for (int r = 0; r < 200; r++) begin
         lancer_roll(3'd4, 4'd15, 3000, -1, -1);
         verif_roll("d12x15", 15, 1, 12);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
